// File: rtl/vgachargen_pkg.sv
// Shared constants, colour-map field layout and CGA palette for the text scan-out.
// Latency: none, this file holds only types and pure functions.
// Backpressure: not applicable.
package vgachargen_pkg;

    // 640x480 at 25 MHz pixel rate from a 100 MHz system clock
    localparam int unsigned DEF_DIVISOR      = 4;
    localparam int unsigned DEF_H_ACTIVE     = 640;
    localparam int unsigned DEF_H_FP         = 16;
    localparam int unsigned DEF_H_SYNC       = 96;
    localparam int unsigned DEF_H_BP         = 48;
    localparam int unsigned DEF_V_ACTIVE     = 480;
    localparam int unsigned DEF_V_FP         = 10;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_BP         = 33;
    localparam int unsigned DEF_GLYPH_W      = 8;
    localparam int unsigned DEF_GLYPH_H      = 16;
    localparam int unsigned DEF_COLOR_W      = 4;
    localparam bit          DEF_SYNC_ACT     = 1'b0;
    localparam int unsigned DEF_BLINK_FRAMES = 32;

    // Colour-map byte: foreground index in the high nibble, background in the low one
    typedef struct packed {
        logic [3:0] fg;
        logic [3:0] bg;
    } colmap_t;

    // Reference CGA palette at 4 bits per channel, packed {R,G,B}
    function automatic logic [11:0] cga_rgb4(input logic [3:0] idx);
        logic [11:0] rgb;
        case (idx)
            4'd0:  rgb = 12'h000;
            4'd1:  rgb = 12'h00A;
            4'd2:  rgb = 12'h0A0;
            4'd3:  rgb = 12'h0AA;
            4'd4:  rgb = 12'hA00;
            4'd5:  rgb = 12'hA0A;
            4'd6:  rgb = 12'hA50;
            4'd7:  rgb = 12'hAAA;
            4'd8:  rgb = 12'h555;
            4'd9:  rgb = 12'h55F;
            4'd10: rgb = 12'h5F5;
            4'd11: rgb = 12'h5FF;
            4'd12: rgb = 12'hF55;
            4'd13: rgb = 12'hF5F;
            4'd14: rgb = 12'hFF5;
            4'd15: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

    // One channel (0=R,1=G,2=B) rescaled from 4 bits to cw bits so 0xF maps to full scale
    function automatic logic [15:0] cga_chan(input logic [3:0] idx, input logic [1:0] ch,
                                             input int unsigned cw);
        logic [11:0] rgb;
        logic [3:0]  v4;
        rgb = cga_rgb4(idx);
        case (ch)
            2'd0:    v4 = rgb[11:8];
            2'd1:    v4 = rgb[7:4];
            default: v4 = rgb[3:0];
        endcase
        return 16'(({28'd0, v4} * ((32'd1 << cw) - 32'd1)) / 32'd15);
    endfunction

endpackage

// File: rtl/vgachargen_scanout_if.sv
// Read-side bundle to the char, colour and glyph RAMs owned outside the scan-out.
// Latency: every data field is expected 1 clock after its address.
// Backpressure: none, the RAMs are always ready.
interface vgachargen_scanout_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned GW = 128
);
    logic [AW-1:0] ch_map_addr;
    logic [7:0]    ch_map_data;
    logic [AW-1:0] col_map_addr;
    logic [7:0]    col_map_data;
    logic [6:0]    ch_t_addr;
    logic [GW-1:0] ch_t_data;

    modport master (
        output ch_map_addr, col_map_addr, ch_t_addr,
        input  ch_map_data, col_map_data, ch_t_data
    );

    modport slave (
        input  ch_map_addr, col_map_addr, ch_t_addr,
        output ch_map_data, col_map_data, ch_t_data
    );
endinterface

// File: rtl/vgachargen_timing.sv
// Pixel-strobe divider plus h/v raster counters and their raw active/sync decodes.
// Latency: decodes are combinational from the counters; counters step on each strobe.
// Backpressure: none, free-running once out of reset.
module vgachargen_timing #(
    parameter int unsigned DIVISOR  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          strb_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          active_o,
    output logic          hs_raw_o,
    output logic          vs_raw_o,
    output logic          frame_start_o
);
    localparam int unsigned DW = $clog2(DIVISOR);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    assign strb_o = (32'(div_q) == DIVISOR - 1);

    // Next divider and raster position; the raster only moves on a strobe
    always_comb begin
        div_d = strb_o ? '0 : div_q + DW'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (strb_o) begin
            if (32'(h_q) == H_TOTAL - 1) begin
                h_d = '0;
                v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign active_o      = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign hs_raw_o      = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw_o      = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    assign frame_start_o = strb_o && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vgachargen_scanout.sv
// Text-mode scan-out: raster -> char/colour fetch -> glyph fetch -> palette RGB with syncs.
// Latency: RGB, de_o and syncs trail the raster counters by exactly 3 pixel strobes.
// Backpressure: none; RAM reads are assumed valid 1 clock after the address moves.
module vgachargen_scanout
    import vgachargen_pkg::*;
#(
    parameter int unsigned DIVISOR      = DEF_DIVISOR,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_FP         = DEF_H_FP,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BP         = DEF_H_BP,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_FP         = DEF_V_FP,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BP         = DEF_V_BP,
    parameter int unsigned GLYPH_W      = DEF_GLYPH_W,
    parameter int unsigned GLYPH_H      = DEF_GLYPH_H,
    parameter int unsigned COLOR_W      = DEF_COLOR_W,
    parameter bit          SYNC_ACT     = DEF_SYNC_ACT,
    parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 blink_en_i,
    vgachargen_scanout_if.master mem,
    output logic [COLOR_W-1:0]   R_o,
    output logic [COLOR_W-1:0]   G_o,
    output logic [COLOR_W-1:0]   B_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic                 frame_start_o
);
    localparam int unsigned COLS  = H_ACTIVE / GLYPH_W;
    localparam int unsigned ROWS  = V_ACTIVE / GLYPH_H;
    localparam int unsigned AW    = $clog2(COLS * ROWS);
    localparam int unsigned GBITS = GLYPH_W * GLYPH_H;
    localparam int unsigned GIW   = $clog2(GBITS);
    localparam int unsigned RW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int unsigned CLW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned FCW   = $clog2(2 * BLINK_FRAMES);

    logic          strb, active, hs_raw, vs_raw, frame_start;
    logic [HW-1:0] h;
    logic [VW-1:0] v;

    vgachargen_timing #(
        .DIVISOR (DIVISOR),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .strb_o       (strb),
        .h_o          (h),
        .v_o          (v),
        .active_o     (active),
        .hs_raw_o     (hs_raw),
        .vs_raw_o     (vs_raw),
        .frame_start_o(frame_start)
    );

    // Stage 1 state: cell address (held through blanking) and position inside the glyph
    logic [AW-1:0]  addr_q, addr_d;
    logic [RW-1:0]  row1_q, row1_d;
    logic [CLW-1:0] col1_q, col1_d;
    logic           act1_q, hs1_q, vs1_q;

    // Stage 2 state: fetched character attributes
    logic [6:0]     cht_q;
    logic           blink2_q, act2_q, hs2_q, vs2_q;
    logic [3:0]     fg2_q, bg2_q;
    logic [RW-1:0]  row2_q;
    logic [CLW-1:0] col2_q;
    colmap_t        cmap;

    // Stage 3 state: pin-facing outputs
    logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic               de_q, hs_q, vs_q;

    // Blink phase is latched at each frame start so a whole frame shares one phase
    logic [FCW-1:0] fc_q;
    logic           phase_q;

    // Cell address for the current raster position; blanking keeps the last one
    always_comb begin
        addr_d = addr_q;
        if (active) begin
            addr_d = AW'((32'(v) / GLYPH_H) * COLS + 32'(h) / GLYPH_W);
        end
    end

    assign row1_d = RW'(32'(v) % GLYPH_H);
    assign col1_d = CLW'(32'(h) % GLYPH_W);
    assign cmap   = colmap_t'(mem.col_map_data);

    // Stage 3 pixel: glyph bit picks fg/bg, blinking chars fall back to bg, blanking is black
    always_comb begin
        logic       pix;
        logic [3:0] pal_idx;
        pix     = mem.ch_t_data[GIW'(GBITS - 1 - (32'(row2_q) * GLYPH_W + 32'(col2_q)))];
        pal_idx = (pix && !(blink_en_i && blink2_q && phase_q)) ? fg2_q : bg2_q;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (act2_q) begin
            r_d = COLOR_W'(cga_chan(pal_idx, 2'd0, COLOR_W));
            g_d = COLOR_W'(cga_chan(pal_idx, 2'd1, COLOR_W));
            b_d = COLOR_W'(cga_chan(pal_idx, 2'd2, COLOR_W));
        end
    end

    // Three-stage pixel pipeline, advanced only on the pixel strobe
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            row1_q   <= '0;
            col1_q   <= '0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            cht_q    <= '0;
            blink2_q <= 1'b0;
            fg2_q    <= '0;
            bg2_q    <= '0;
            row2_q   <= '0;
            col2_q   <= '0;
            act2_q   <= 1'b0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            de_q     <= 1'b0;
            hs_q     <= !SYNC_ACT;
            vs_q     <= !SYNC_ACT;
        end else if (strb) begin
            addr_q   <= addr_d;
            row1_q   <= row1_d;
            col1_q   <= col1_d;
            act1_q   <= active;
            hs1_q    <= hs_raw;
            vs1_q    <= vs_raw;
            cht_q    <= mem.ch_map_data[6:0];
            blink2_q <= mem.ch_map_data[7];
            fg2_q    <= cmap.fg;
            bg2_q    <= cmap.bg;
            row2_q   <= row1_q;
            col2_q   <= col1_q;
            act2_q   <= act1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            de_q     <= act2_q;
            hs_q     <= hs2_q ? SYNC_ACT : !SYNC_ACT;
            vs_q     <= vs2_q ? SYNC_ACT : !SYNC_ACT;
        end
    end

    // Frame counter for the blink cadence
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fc_q    <= '0;
            phase_q <= 1'b0;
        end else if (frame_start) begin
            fc_q    <= fc_q + FCW'(1);
            phase_q <= fc_q[FCW-1];
        end
    end

    assign mem.ch_map_addr  = addr_q;
    assign mem.col_map_addr = addr_q;
    assign mem.ch_t_addr    = cht_q;
    assign R_o              = r_q;
    assign G_o              = g_q;
    assign B_o              = b_q;
    assign de_o             = de_q;
    assign hsync_o          = hs_q;
    assign vsync_o          = vs_q;
    assign frame_start_o    = frame_start;

endmodule

// File: tb/tb_vgachargen_scanout.sv
module tb_vgachargen_scanout;
    // Shrunken raster so many frames fit in a short run
    localparam int D = 3;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int GW = 4,  GH = 4, CW = 4, BF = 2;
    localparam bit SA = 1'b0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FS = HT * VT;
    localparam int COLS = HA / GW, ROWS = VA / GH;
    localparam int AW = 3, GB = GW * GH;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic blink_en_i = 1'b1;
    logic [CW-1:0] R_o, G_o, B_o;
    logic hsync_o, vsync_o, de_o, frame_start_o;

    vgachargen_scanout_if #(.AW(AW), .GW(GB)) mem_if ();

    vgachargen_scanout #(
        .DIVISOR(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .GLYPH_W(GW), .GLYPH_H(GH), .COLOR_W(CW), .SYNC_ACT(SA), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .blink_en_i(blink_en_i), .mem(mem_if),
        .R_o(R_o), .G_o(G_o), .B_o(B_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .de_o(de_o), .frame_start_o(frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    // External RAMs with one-clock read latency
    logic [7:0]    ch_mem [COLS*ROWS];
    logic [7:0]    col_mem[COLS*ROWS];
    logic [GB-1:0] gl_mem [128];

    always @(posedge clk_i) begin
        mem_if.ch_map_data  <= ch_mem[mem_if.ch_map_addr];
        mem_if.col_map_data <= col_mem[mem_if.col_map_addr];
        mem_if.ch_t_data    <= gl_mem[mem_if.ch_t_addr];
    end

    logic [11:0] pal[16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                             12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    int n_tests = 0, n_fail = 0;
    int cyc, sess, model_addr, de_cnt, hs_cnt, vs_cnt;
    logic [31:0] exp_pix, exp_addr, exp_cht;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pix_vec(input logic [11:0] rgb, input logic de, input logic hs,
                                            input logic vs);
        return {17'd0, rgb, de, hs, vs};
    endfunction

    function automatic logic [31:0] obs_pix();
        return {17'd0, R_o, G_o, B_o, de_o, hsync_o, vsync_o};
    endfunction

    // Expected screen contents for strobe k (k-th strobe since reset release)
    task automatic model_strobe(input int k);
        int p, hp, vp, a, f, bi;
        logic [7:0] c, cl;
        logic [GB-1:0] g;
        logic b, act, hs, vs;
        logic [3:0] idx;
        logic [11:0] rgb;
        exp_cht = {25'd0, ch_mem[model_addr][6:0]};
        p = k % FS; hp = p % HT; vp = p / HT;
        if (hp < HA && vp < VA) model_addr = (vp / GH) * COLS + hp / GW;
        exp_addr = model_addr;
        rgb = '0; act = 1'b0; hs = !SA; vs = !SA;
        if (k >= 2) begin
            p = (k - 2) % FS; hp = p % HT; vp = p / HT; f = (k - 2) / FS;
            act = (hp < HA) && (vp < VA);
            hs = (hp >= HA + HF && hp < HA + HF + HS) ? SA : !SA;
            vs = (vp >= VA + VF && vp < VA + VF + VS) ? SA : !SA;
            if (act) begin
                a = (vp / GH) * COLS + hp / GW;
                c = ch_mem[a]; cl = col_mem[a]; g = gl_mem[c[6:0]];
                bi = GB - 1 - ((vp % GH) * GW + hp % GW);
                b = g[bi];
                idx = (b && !(blink_en_i && c[7] && ((f / BF) % 2 == 1))) ? cl[7:4] : cl[3:0];
                rgb = pal[idx];
            end
        end
        exp_pix = pix_vec(rgb, act, hs, vs);
        chk("pix", obs_pix(), exp_pix);
        chk("ch_addr", 32'(mem_if.ch_map_addr), exp_addr);
        chk("col_addr", 32'(mem_if.col_map_addr), exp_addr);
        chk("cht_addr", 32'(mem_if.ch_t_addr), exp_cht);
    endtask

    // Hand-computed spot checks on the first session
    task automatic directed(input int k);
        int f, p;
        f = k / FS; p = k % FS;
        if (f == 0 && p >= 2 && p <= 5) chk("render", {20'd0, R_o, G_o, B_o}, (p < 4) ? 32'h00A : 32'hFFF);
        if (p == 6 && f == 0) chk("blink_shown", {20'd0, R_o, G_o, B_o}, 32'h00A);
        if (p == 6 && f == 2) chk("blink_hidden", {20'd0, R_o, G_o, B_o}, 32'hFFF);
        if (p == 6 && f == 6) chk("blink_disabled", {20'd0, R_o, G_o, B_o}, 32'h00A);
        if (p == 7 * HT + 15) chk("addr_last", 32'(mem_if.ch_map_addr), 32'd7);
        if (p == 7 * HT + 20) chk("addr_hold", 32'(mem_if.ch_map_addr), 32'd7);
    endtask

    task automatic step();
        int k;
        logic fs_exp;
        @(posedge clk_i); #1;
        cyc++;
        if (cyc % D == 0) begin
            k = cyc / D - 1;
            model_strobe(k);
            if (sess == 0) directed(k);
            if (k % FS == 2) begin
                if (k >= FS + 2) begin
                    chk("de_clks_per_frame", de_cnt, HA * VA * D);
                    chk("hs_clks_per_frame", hs_cnt, VT * HS * D);
                    chk("vs_clks_per_frame", vs_cnt, VS * HT * D);
                end
                de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
            end
            if (k % FS == FS - 10) blink_en_i = !((k / FS + 1 == 6) || (k / FS + 1 == 7));
        end else begin
            chk("hold_pix", obs_pix(), exp_pix);
            chk("hold_addr", 32'(mem_if.ch_map_addr), exp_addr);
        end
        fs_exp = ((cyc + 1) % D == 0) && (((cyc + 1) / D - 1) % FS == 0);
        chk("frame_start", {31'd0, frame_start_o}, {31'd0, fs_exp});
        de_cnt += int'(de_o);
        hs_cnt += (hsync_o == SA) ? 1 : 0;
        vs_cnt += (vsync_o == SA) ? 1 : 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pix"}, obs_pix(), pix_vec(12'h000, 1'b0, !SA, !SA));
        chk({tag, "_addr"}, 32'(mem_if.ch_map_addr), 32'd0);
        chk({tag, "_cht"}, 32'(mem_if.ch_t_addr), 32'd0);
        chk({tag, "_fs"}, {31'd0, frame_start_o}, 32'd0);
    endtask

    task automatic release_reset();
        exp_pix = pix_vec(12'h000, 1'b0, !SA, !SA);
        exp_addr = 0; model_addr = 0; cyc = 0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        rst_ni = 1'b1;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < COLS * ROWS; i++) begin
            ch_mem[i] = 8'($urandom);
            col_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 128; i++) gl_mem[i] = GB'($urandom);
        ch_mem[0] = 8'h41; col_mem[0] = 8'h1F;
        ch_mem[1] = 8'hC1; col_mem[1] = 8'h1F;
        gl_mem[7'h41] = {4'hC, 12'($urandom)};
        sess = 0;

        rst_ni = 1'b0;
        blink_en_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check_reset("rst");
        release_reset();
        repeat (9 * FS * D) step();

        // Reset in the middle of a frame, at v=5
        guard = 0;
        while (!((cyc % D == 0) && ((cyc / D - 1) % FS == 5 * HT)) && guard < FS * D + 10) begin
            step();
            guard++;
        end
        chk("mid_reset_reached", {31'd0, guard < FS * D + 10}, 32'd1);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check_reset("mrst");
        repeat (2) @(posedge clk_i);
        #1;
        sess = 1;
        blink_en_i = 1'b1;
        release_reset();
        repeat (2 * FS * D) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
